// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage: SP op codes, sequencer states,
// and the default stack-pointer register index.
package wb_pkg;

  localparam logic [1:0] SP_OP_NONE = 2'b00;
  localparam logic [1:0] SP_OP_INC  = 2'b01;
  localparam logic [1:0] SP_OP_DEC  = 2'b10;
  localparam logic [1:0] SP_OP_ILL  = 2'b11;

  localparam int unsigned SP_ADDR_DEFAULT = 3;

  typedef enum logic [1:0] {
    EMPTY,
    ACT_WR,
    ACT_SP
  } state_t;

endpackage

// File: rtl/wb_stage.sv
// MEM/WB hold register and writeback sequencer: issues the register write first and
// any owed SP update in a following cycle, so WE never coincides with IncSP/DecSP.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned SP_ADDR = SP_ADDR_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sp_op,
  output logic              WE,
  output logic [ADDR_W-1:0] RW_addr,
  output logic [DATA_W-1:0] WD,
  output logic              IncSP,
  output logic              DecSP,
  output logic              fwd_valid,
  output logic              sp_pending,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              err_sp
);

  state_t            state;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        op_q;

  logic op_live;
  logic completing;
  logic accept;
  logic in_ill;
  logic drop_sp;

  // op_q only ever holds NONE, INC or DEC; illegal and conflicting ops are cleared on load.
  assign op_live    = (op_q == SP_OP_INC) || (op_q == SP_OP_DEC);
  assign completing = (state == ACT_SP) || ((state == ACT_WR) && !op_live);
  assign in_ready   = (state == EMPTY) || completing;
  assign accept     = in_valid && in_ready;
  assign in_ill     = (in_sp_op == SP_OP_ILL);
  assign drop_sp    = in_reg_write && (in_rd == ADDR_W'(SP_ADDR)) && (in_sp_op != SP_OP_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      rd_q        <= '0;
      data_q      <= '0;
      op_q        <= SP_OP_NONE;
      retired_cnt <= '0;
      err_sp      <= 1'b0;
    end else begin
      if (completing) retired_cnt <= retired_cnt + CNT_W'(1);
      if (accept && (in_ill || drop_sp)) err_sp <= 1'b1;

      if ((state == ACT_WR) && op_live) begin
        state <= ACT_SP;
      end else if (accept) begin
        // A nop entry rides through ACT_SP with op NONE: one cycle, no strobe, still retires.
        state  <= in_reg_write ? ACT_WR : ACT_SP;
        rd_q   <= in_rd;
        data_q <= in_data;
        op_q   <= (in_ill || drop_sp) ? SP_OP_NONE : in_sp_op;
      end else if (completing) begin
        state <= EMPTY;
      end
    end
  end

  assign WE         = (state == ACT_WR);
  assign RW_addr    = WE ? rd_q : '0;
  assign WD         = WE ? data_q : '0;
  assign IncSP      = (state == ACT_SP) && (op_q == SP_OP_INC);
  assign DecSP      = (state == ACT_SP) && (op_q == SP_OP_DEC);
  assign fwd_valid  = WE;
  assign sp_pending = (state != EMPTY) && op_live;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed offers push expected regfile strobes,
// a negedge monitor pops and compares them and maintains a model register file.
module tb_wb_stage;

  typedef struct packed {
    logic       we;
    logic [1:0] rd;
    logic [7:0] data;
    logic       inc;
    logic       dec;
  } act_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_reg_write;
  logic [1:0] in_rd;
  logic [7:0] in_data;
  logic [1:0] in_sp_op;
  logic       WE;
  logic [1:0] RW_addr;
  logic [7:0] WD;
  logic       IncSP;
  logic       DecSP;
  logic       fwd_valid;
  logic       sp_pending;
  logic [15:0] retired_cnt;
  logic       err_sp;

  int tests = 0;
  int fails = 0;
  act_t exp_q[$];
  logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h80};

  wb_stage #(.DATA_W(8), .ADDR_W(2), .SP_ADDR(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_data(in_data), .in_sp_op(in_sp_op),
    .WE(WE), .RW_addr(RW_addr), .WD(WD), .IncSP(IncSP), .DecSP(DecSP),
    .fwd_valid(fwd_valid), .sp_pending(sp_pending),
    .retired_cnt(retired_cnt), .err_sp(err_sp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic we, input logic [1:0] rd, input logic [7:0] data,
                          input logic inc, input logic dec);
    act_t a;
    a.we = we; a.rd = rd; a.data = data; a.inc = inc; a.dec = dec;
    exp_q.push_back(a);
  endtask

  // Present one entry; returns after the accepting edge (+1) with the stall count.
  task automatic offer(input logic rw, input logic [1:0] rd, input logic [7:0] data,
                       input logic [1:0] op, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_data = data; in_sp_op = op;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_data = '0; in_sp_op = '0;
    if (!got) check("offer_timeout", 32'd0, 32'd1);
  endtask

  // Model regfile driven by the DUT's write side.
  always @(posedge clk) begin
    if (rst_n) begin
      if (WE) regs[RW_addr] <= WD;
      if (IncSP) regs[3] <= regs[3] + 8'd1;
      if (DecSP) regs[3] <= regs[3] - 8'd1;
    end
  end

  // Monitor: per-cycle invariants and scoreboard pop on every strobe.
  always @(negedge clk) begin
    act_t got_a;
    act_t want_a;
    if (rst_n) begin
      check("strobe_mutex", {31'd0, (WE && (IncSP || DecSP)) || (IncSP && DecSP)}, 32'd0);
      check("fwd_eq_we", {31'd0, fwd_valid}, {31'd0, WE});
      if (WE || IncSP || DecSP) begin
        got_a.we = WE; got_a.rd = RW_addr; got_a.data = WD; got_a.inc = IncSP; got_a.dec = DecSP;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {19'd0, got_a}, 32'd0);
        end else begin
          want_a = exp_q.pop_front();
          check("strobe", {19'd0, got_a}, {19'd0, want_a});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_data = '0; in_sp_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // 1: reset state
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_inc_dec", {30'd0, IncSP, DecSP}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_cnt", {16'd0, retired_cnt}, 32'd0);
    check("rst_err", {31'd0, err_sp}, 32'd0);
    check("rst_pend", {31'd0, sp_pending}, 32'd0);
    check("rst_addr_wd", {22'd0, RW_addr, WD}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: single write
    push_exp(1'b1, 2'd0, 8'h11, 1'b0, 1'b0);
    offer(1'b1, 2'd0, 8'h11, 2'b00, w);
    @(posedge clk); #1;
    check("s2_cnt", {16'd0, retired_cnt}, 32'd1);
    check("s2_r0", {24'd0, regs[0]}, 32'h11);

    // 3: write then IncSP
    push_exp(1'b1, 2'd1, 8'h5A, 1'b0, 1'b0);
    push_exp(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    offer(1'b1, 2'd1, 8'h5A, 2'b01, w);
    @(negedge clk);
    check("s3_c1_ready", {31'd0, in_ready}, 32'd0);
    check("s3_c1_pend", {31'd0, sp_pending}, 32'd1);
    @(negedge clk);
    check("s3_c2_ready", {31'd0, in_ready}, 32'd1);
    check("s3_c2_pend", {31'd0, sp_pending}, 32'd1);
    @(posedge clk); #1;
    check("s3_cnt", {16'd0, retired_cnt}, 32'd2);
    check("s3_r1", {24'd0, regs[1]}, 32'h5A);
    check("s3_sp", {24'd0, regs[3]}, 32'h81);

    // 4: back-to-back single-action entries
    push_exp(1'b1, 2'd0, 8'h01, 1'b0, 1'b0);
    push_exp(1'b1, 2'd1, 8'h02, 1'b0, 1'b0);
    push_exp(1'b1, 2'd2, 8'h03, 1'b0, 1'b0);
    push_exp(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    offer(1'b1, 2'd0, 8'h01, 2'b00, w); check("s4_stall0", w, 32'd0);
    offer(1'b1, 2'd1, 8'h02, 2'b00, w); check("s4_stall1", w, 32'd0);
    offer(1'b1, 2'd2, 8'h03, 2'b00, w); check("s4_stall2", w, 32'd0);
    offer(1'b0, 2'd0, 8'h00, 2'b10, w); check("s4_stall3", w, 32'd0);
    @(posedge clk); #1;
    check("s4_cnt", {16'd0, retired_cnt}, 32'd6);
    check("s4_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'h01020380);

    // 5: write to SP with SP op, then illegal op
    push_exp(1'b1, 2'd3, 8'hAA, 1'b0, 1'b0);
    offer(1'b1, 2'd3, 8'hAA, 2'b10, w);
    @(negedge clk);
    check("s5_pend", {31'd0, sp_pending}, 32'd0);
    @(posedge clk); #1;
    check("s5_err", {31'd0, err_sp}, 32'd1);
    check("s5_cnt", {16'd0, retired_cnt}, 32'd7);
    check("s5_sp", {24'd0, regs[3]}, 32'hAA);
    offer(1'b0, 2'd0, 8'h00, 2'b11, w);
    @(posedge clk); #1;
    check("s5_ill_err", {31'd0, err_sp}, 32'd1);
    check("s5_ill_cnt", {16'd0, retired_cnt}, 32'd8);

    // 6: reset during ACT_WR of a two-action entry
    push_exp(1'b1, 2'd2, 8'h77, 1'b0, 1'b0);
    offer(1'b1, 2'd2, 8'h77, 2'b01, w);
    @(negedge clk);
    check("s6_pend", {31'd0, sp_pending}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("s6_rst_we", {31'd0, WE}, 32'd0);
    check("s6_rst_pend", {31'd0, sp_pending}, 32'd0);
    check("s6_rst_cnt", {16'd0, retired_cnt}, 32'd0);
    check("s6_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("s6_cnt", {16'd0, retired_cnt}, 32'd0);
    check("s6_err", {31'd0, err_sp}, 32'd0);
    check("s6_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'h010203AA);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
